// File: rtl/pipeline_stall_controller_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the stall controller (slave).
// Perf counter signals exist only when HAZ_PERF_CNT_EN is defined.
interface pipeline_stall_controller_if
`ifdef HAZ_PERF_CNT_EN
  #(parameter int unsigned CntW = 32)
`endif
  ;
  logic       mem_read_e;
  logic [4:0] rd_e;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic       mul_div_e;
  logic       md_done;
  logic       branch_or_jump;
  logic       trap_req;

  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_d;
  logic       flush_e;
  logic       flush_m;
  logic       md_start;
  logic       md_kill;
  logic       md_timeout;
`ifdef HAZ_PERF_CNT_EN
  logic [CntW-1:0] stall_cnt;
  logic [CntW-1:0] flush_cnt;
`endif

  modport master (
    output mem_read_e, rd_e, rs1_d, rs2_d, mul_div_e, md_done, branch_or_jump, trap_req,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_start, md_kill, md_timeout
`ifdef HAZ_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  mem_read_e, rd_e, rs1_d, rs2_d, mul_div_e, md_done, branch_or_jump, trap_req,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_start, md_kill, md_timeout
`ifdef HAZ_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Hazard sequencer: load-use bubbles, multi-cycle mul/div stalls, branch/trap flushes.
// Optional stall/flush perf counters are built when HAZ_PERF_CNT_EN is defined.
module pipeline_stall_controller #(
  parameter int unsigned MdMaxCyc = 64
`ifdef HAZ_PERF_CNT_EN
  ,
  parameter int unsigned CntW = 32
`endif
) (
  input logic                        clk_i,
  input logic                        rst_ni,
  pipeline_stall_controller_if.slave ctrl
);

  typedef enum logic {StRun, StBusy} state_e;

  localparam int unsigned        BusyW   = $clog2(MdMaxCyc + 1);
  localparam logic [BusyW-1:0]   BusyMax = BusyW'(MdMaxCyc);

  state_e           state_q, state_d;
  logic [BusyW-1:0] busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic load_use;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, flush_m;
  logic md_start, md_kill;

  assign load_use = ctrl.mem_read_e && (ctrl.rd_e != 5'd0) &&
                    ((ctrl.rd_e == ctrl.rs1_d) || (ctrl.rd_e == ctrl.rs2_d));

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    timeout_d = timeout_q;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    stall_e   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    flush_m   = 1'b0;
    md_start  = 1'b0;
    md_kill   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (ctrl.trap_req) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
          flush_m = 1'b1;
        end else if (ctrl.branch_or_jump) begin
          // ID is flushed, so a simultaneous load-use hit needs no bubble.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (ctrl.mul_div_e) begin
          md_start = 1'b1;
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          flush_m  = 1'b1;
          state_d  = StBusy;
          busy_d   = BusyW'(1);
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      StBusy: begin
        if (ctrl.trap_req) begin
          md_kill = 1'b1;
          flush_d = 1'b1;
          flush_e = 1'b1;
          flush_m = 1'b1;
          state_d = StRun;
          busy_d  = '0;
        end else if (ctrl.md_done) begin
          state_d = StRun;
          busy_d  = '0;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          busy_d  = (busy_q == BusyMax) ? busy_q : busy_q + BusyW'(1);
          if (busy_d == BusyMax) timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StRun;
      busy_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  // Controls are held low while reset is asserted, whatever the inputs do.
  assign ctrl.stall_f    = rst_ni & stall_f;
  assign ctrl.stall_d    = rst_ni & stall_d;
  assign ctrl.stall_e    = rst_ni & stall_e;
  assign ctrl.flush_d    = rst_ni & flush_d;
  assign ctrl.flush_e    = rst_ni & flush_e;
  assign ctrl.flush_m    = rst_ni & flush_m;
  assign ctrl.md_start   = rst_ni & md_start;
  assign ctrl.md_kill    = rst_ni & md_kill;
  assign ctrl.md_timeout = timeout_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CntW-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_q + CntW'(stall_f);
      flush_cnt_q <= flush_cnt_q + CntW'(flush_d);
    end
  end

  assign ctrl.stall_cnt = stall_cnt_q;
  assign ctrl.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Self-checking bench for pipeline_stall_controller: vector table, directed sequences and
// random stimulus against a cycle-level behavioural model. Honours HAZ_PERF_CNT_EN.
module tb_pipeline_stall_controller;
  localparam int unsigned MaxCyc = 64;
`ifdef HAZ_PERF_CNT_EN
  localparam int unsigned CntW = 32;
`endif

  typedef struct packed {
    logic       mr;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       muldiv;
    logic       done;
    logic       branch;
    logic       trap;
  } in_t;

  typedef struct packed {
    logic sf, sd, se, fd, fe, fm, start, kill, to;
  } ctl_t;

  typedef struct {
    in_t   in;
    ctl_t  exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

`ifdef HAZ_PERF_CNT_EN
  pipeline_stall_controller_if #(.CntW(CntW)) bus ();
  pipeline_stall_controller #(.MdMaxCyc(MaxCyc), .CntW(CntW)) dut (
`else
  pipeline_stall_controller_if bus ();
  pipeline_stall_controller #(.MdMaxCyc(MaxCyc)) dut (
`endif
    .clk_i (clk),
    .rst_ni(rst_n),
    .ctrl  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: mul/div in flight, cycles since issue, sticky timeout, event counts.
  bit          m_busy;
  int          m_cycles;
  bit          m_timeout;
  logic [31:0] m_stall_cnt;
  logic [31:0] m_flush_cnt;

  function automatic in_t mk(logic mr, int rd, int rs1, int rs2,
                             logic muldiv, logic done, logic branch, logic trap);
    in_t i;
    i.mr = mr; i.rd = 5'(rd); i.rs1 = 5'(rs1); i.rs2 = 5'(rs2);
    i.muldiv = muldiv; i.done = done; i.branch = branch; i.trap = trap;
    return i;
  endfunction

  function automatic ctl_t model_out(in_t i);
    ctl_t o = '0;
    bit   hit = i.mr && (i.rd != 0) && ((i.rd == i.rs1) || (i.rd == i.rs2));
    if (m_busy) begin
      if (i.trap) begin
        o.kill = 1; o.fd = 1; o.fe = 1; o.fm = 1;
      end else if (!i.done) begin
        o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1;
      end
    end else if (i.trap) begin
      o.fd = 1; o.fe = 1; o.fm = 1;
    end else if (i.branch) begin
      o.fd = 1; o.fe = 1;
    end else if (i.muldiv) begin
      o.start = 1; o.sf = 1; o.sd = 1; o.se = 1; o.fm = 1;
    end else if (hit) begin
      o.sf = 1; o.sd = 1; o.fe = 1;
    end
    o.to = m_timeout;
    return o;
  endfunction

  function automatic void model_update(in_t i, ctl_t o);
    if (o.sf) m_stall_cnt = m_stall_cnt + 1;
    if (o.fd) m_flush_cnt = m_flush_cnt + 1;
    if (m_busy) begin
      if (i.trap || i.done) begin
        m_busy = 0; m_cycles = 0;
      end else begin
        m_cycles++;
        if (m_cycles >= MaxCyc) m_timeout = 1;
      end
    end else if (!i.trap && !i.branch && i.muldiv) begin
      m_busy = 1; m_cycles = 1;
    end
  endfunction

  function automatic void model_reset();
    m_busy = 0; m_cycles = 0; m_timeout = 0; m_stall_cnt = '0; m_flush_cnt = '0;
  endfunction

  task automatic apply(in_t i);
    bus.mem_read_e     = i.mr;
    bus.rd_e           = i.rd;
    bus.rs1_d          = i.rs1;
    bus.rs2_d          = i.rs2;
    bus.mul_div_e      = i.muldiv;
    bus.md_done        = i.done;
    bus.branch_or_jump = i.branch;
    bus.trap_req       = i.trap;
  endtask

  function automatic ctl_t sample();
    return {bus.stall_f, bus.stall_d, bus.stall_e, bus.flush_d, bus.flush_e, bus.flush_m,
            bus.md_start, bus.md_kill, bus.md_timeout};
  endfunction

  task automatic check_ctl(string name, ctl_t act, ctl_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sf,sd,se,fd,fe,fm,start,kill,to=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_cnt(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_counters(string name);
`ifdef HAZ_PERF_CNT_EN
    check_cnt({name, "_stall_cnt"}, bus.stall_cnt, m_stall_cnt);
    check_cnt({name, "_flush_cnt"}, bus.flush_cnt, m_flush_cnt);
`else
    name = name;
`endif
  endtask

  // Entered just after a rising edge; drives, checks mid-cycle, then clocks the model.
  task automatic step(in_t i, ctl_t exp, string name, bit use_model);
    ctl_t mo;
    apply(i);
    #1;
    mo = model_out(i);
    check_ctl(name, sample(), use_model ? mo : exp);
    @(posedge clk);
    model_update(i, mo);
    #1;
    check_counters(name);
  endtask

  in_t  idle;
  in_t  md;
  in_t  t;
  ctl_t e;
  vec_t tbl[14];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
    md   = mk(0, 0, 0, 0, 1, 0, 0, 0);
    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0), 9'b000_000_000, "idle"};
    tbl[1]  = '{mk(1, 5, 0, 5, 0, 0, 0, 0), 9'b110_010_000, "loaduse_rs2"};
    tbl[2]  = '{mk(1, 7, 7, 3, 0, 0, 0, 0), 9'b110_010_000, "loaduse_rs1"};
    tbl[3]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0), 9'b000_000_000, "x0_load"};
    tbl[4]  = '{mk(1, 5, 6, 7, 0, 0, 0, 0), 9'b000_000_000, "load_nomatch"};
    tbl[5]  = '{mk(0, 5, 5, 5, 0, 0, 0, 0), 9'b000_000_000, "nonload_match"};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 0, 1, 0), 9'b000_110_000, "branch"};
    tbl[7]  = '{mk(1, 9, 9, 0, 0, 0, 1, 0), 9'b000_110_000, "branch_loaduse"};
    tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 0, 1), 9'b000_111_000, "trap"};
    tbl[9]  = '{mk(1, 4, 4, 4, 1, 0, 1, 1), 9'b000_111_000, "trap_beats_all"};
    tbl[10] = '{mk(0, 0, 0, 0, 1, 0, 0, 0), 9'b111_001_100, "muldiv_start"};
    tbl[11] = '{mk(1, 3, 3, 0, 1, 0, 0, 0), 9'b111_001_100, "muldiv_beats_loaduse"};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 1, 0, 0), 9'b000_000_000, "done_in_run"};
    tbl[13] = '{mk(0, 0, 0, 0, 1, 0, 1, 0), 9'b000_110_000, "branch_beats_muldiv"};

    // Reset: outputs stay low even with hazards presented.
    rst_n = 1'b0;
    model_reset();
    apply(mk(1, 5, 5, 5, 1, 1, 1, 1));
    #3;
    check_ctl("reset_outputs", sample(), '0);
    check_counters("reset");
    apply(idle);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Combinational vectors in RUN; inputs return to idle before each edge.
    foreach (tbl[k]) begin
      @(negedge clk);
      apply(tbl[k].in);
      #1;
      check_ctl(tbl[k].name, sample(), tbl[k].exp);
      apply(idle);
    end
    @(posedge clk);
    #1;

    // Load-use bubble lasts one cycle; x0 destination never stalls.
    step(mk(1, 5, 0, 5, 0, 0, 0, 0), 9'b110_010_000, "lu_hit", 0);
    step(idle, 9'b000_000_000, "lu_after", 0);
    step(mk(1, 0, 0, 0, 0, 0, 0, 0), 9'b000_000_000, "lu_x0", 0);

    // Mul/div completing on cycle 4; branch during BUSY is ignored.
    step(md, 9'b111_001_100, "md4_issue", 0);
    for (int k = 1; k <= 3; k++) begin
      t = md;
      t.branch = (k == 2);
      step(t, 9'b111_001_000, "md4_busy", 0);
    end
    t = md; t.done = 1;
    step(t, 9'b000_000_000, "md4_done", 0);
    step(idle, 9'b000_000_000, "md4_run", 0);
    step(md, 9'b111_001_100, "md4_reissue", 0);
    t = md; t.done = 1;
    step(t, 9'b000_000_000, "md4_done2", 0);

    // Trap in the second BUSY cycle kills the MD op.
    step(md, 9'b111_001_100, "trap_issue", 0);
    step(md, 9'b111_001_000, "trap_busy1", 0);
    t = md; t.trap = 1;
    step(t, 9'b000_111_010, "trap_kill", 0);
    step(mk(1, 6, 6, 0, 0, 0, 0, 0), 9'b110_010_000, "trap_run", 0);

    // Branch and load-use together: flush only.
    step(mk(1, 5, 0, 5, 0, 0, 1, 0), 9'b000_110_000, "br_lu", 0);

    // Random stimulus against the model.
    for (int n = 0; n < 400; n++) begin
      t.mr     = ($urandom_range(1, 0) == 1);
      t.rd     = 5'($urandom_range(3, 0));
      t.rs1    = 5'($urandom_range(3, 0));
      t.rs2    = 5'($urandom_range(3, 0));
      t.muldiv = ($urandom_range(3, 0) == 0);
      t.done   = ($urandom_range(3, 0) == 0);
      t.branch = ($urandom_range(7, 0) == 0);
      t.trap   = ($urandom_range(15, 0) == 0);
      step(t, '0, "random", 1);
    end

    // Fresh reset, then the timeout run.
    rst_n = 1'b0;
    model_reset();
    apply(idle);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(md, 9'b111_001_100, "to_issue", 0);
    for (int k = 1; k <= 70; k++) begin
      e = 9'b111_001_000;
      e.to = (k >= MaxCyc);
      step(md, e, $sformatf("to_busy%0d", k), 0);
    end
    t = md; t.trap = 1;
    step(t, 9'b000_111_011, "to_kill", 0);
    step(idle, 9'b000_000_001, "to_sticky", 0);

    // Reset mid-BUSY: immediate RUN, no kill pulse, timeout cleared.
    rst_n = 1'b0;
    model_reset();
    #1;
    check_ctl("to_reset", sample(), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(md, 9'b111_001_100, "rmb_issue", 0);
    step(md, 9'b111_001_000, "rmb_busy", 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_ctl("rmb_in_reset", sample(), '0);
    @(posedge clk);
    #1;
    check_ctl("rmb_held", sample(), '0);
    check_counters("rmb");
    rst_n = 1'b1;
    step(idle, 9'b000_000_000, "rmb_run", 0);
    step(mk(1, 2, 0, 2, 0, 0, 0, 0), 9'b110_010_000, "rmb_loaduse", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
